// File: rtl/timer_apb_sequencer.sv
// -----------------------------------------------------------------------------
// timer_apb_sequencer
//
// Programs a memory-mapped timer over APB, then polls its status register.
// It counts overflow or underflow events until a configured number of periods
// has been seen. After that it stops the timer and pulses done.
//
// Ports
//   pclk, presetn      : clock (rising edge) and asynchronous active-low reset
//   start              : run request pulse, sampled only while idle
//   abort              : stop request (level); honoured between transfers
//   cfg_tdr            : timer preload value
//   cfg_down           : count direction (0 = up, 1 = down)
//   cfg_cks            : timer clock select
//   cfg_periods        : number of flag events to count (0 behaves as 1)
//   psel .. pwdata     : APB master request outputs
//   prdata, pready,
//   pslverr            : APB slave response inputs
//   busy               : a run is in progress
//   done               : one-cycle pulse at the end of a run
//   err                : sticky slave-error indication for the current run
//   period_cnt         : flag events counted so far (saturating)
// -----------------------------------------------------------------------------
module timer_apb_sequencer #(
  parameter logic [7:0] ADDR_TDR = 8'h00,
  parameter logic [7:0] ADDR_TCR = 8'h01,
  parameter logic [7:0] ADDR_TSR = 8'h02,
  parameter int         POLL_GAP = 4
) (
  input  logic       pclk,
  input  logic       presetn,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] cfg_tdr,
  input  logic       cfg_down,
  input  logic [1:0] cfg_cks,
  input  logic [7:0] cfg_periods,
  output logic       psel,
  output logic       penable,
  output logic       pwrite,
  output logic [7:0] paddr,
  output logic [7:0] pwdata,
  input  logic [7:0] prdata,
  input  logic       pready,
  input  logic       pslverr,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [7:0] period_cnt
);

  localparam logic [3:0] IDLE    = 4'd0;
  localparam logic [3:0] WR_TDR  = 4'd1;
  localparam logic [3:0] WR_LOAD = 4'd2;
  localparam logic [3:0] WR_RUN  = 4'd3;
  localparam logic [3:0] GAP     = 4'd4;
  localparam logic [3:0] RD_TSR  = 4'd5;
  localparam logic [3:0] CLR_TSR = 4'd6;
  localparam logic [3:0] STOP    = 4'd7;
  localparam logic [3:0] DONE    = 4'd8;

  localparam logic [7:0] GAP_LAST = 8'(POLL_GAP - 1);

  logic [3:0] state_reg, state_next;
  logic [7:0] tdr_reg;
  logic       down_reg;
  logic [1:0] cks_reg;
  logic [7:0] target_reg;
  logic       abort_reg;
  logic [7:0] gap_reg;

  logic       err_next;
  logic [7:0] cnt_next;
  logic       xfer_done;
  logic       abort_any;
  logic       flag_set;
  logic [7:0] cnt_inc;
  logic       launch;
  logic [7:0] tdr_src;
  logic [7:0] setup_addr;
  logic       setup_write;
  logic [7:0] setup_data;

  // A transfer completes on the edge where the access phase meets pready.
  assign xfer_done = psel & penable & pready;
  // The abort level is latched so that a short request raised mid-transfer
  // still stops the run once that transfer has finished.
  assign abort_any = abort_reg | abort;
  // Down-counting runs watch underflow (TSR[1]); up-counting runs watch
  // overflow (TSR[0]).
  assign flag_set  = |(prdata & (down_reg ? 8'h02 : 8'h01));
  assign cnt_inc   = (period_cnt == 8'hFF) ? 8'hFF : period_cnt + 8'd1;

  always_comb begin
    state_next = state_reg;
    err_next   = err;
    cnt_next   = period_cnt;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = WR_TDR;
          err_next   = 1'b0;
          cnt_next   = 8'd0;
        end
      end
      WR_TDR, WR_LOAD, WR_RUN: begin
        if (xfer_done) begin
          if (pslverr) begin
            err_next   = 1'b1;
            state_next = STOP;
          end else if (abort_any) begin
            state_next = STOP;
          end else if (state_reg == WR_TDR) begin
            state_next = WR_LOAD;
          end else if (state_reg == WR_LOAD) begin
            state_next = WR_RUN;
          end else begin
            state_next = GAP;
          end
        end
      end
      GAP: begin
        if (abort_any) begin
          state_next = STOP;
        end else if (gap_reg == GAP_LAST) begin
          state_next = RD_TSR;
        end
      end
      RD_TSR: begin
        if (xfer_done) begin
          if (pslverr) begin
            err_next   = 1'b1;
            state_next = STOP;
          end else begin
            if (flag_set) begin
              cnt_next = cnt_inc;
            end
            if (abort_any) begin
              state_next = STOP;
            end else if (flag_set) begin
              state_next = CLR_TSR;
            end else begin
              state_next = GAP;
            end
          end
        end
      end
      CLR_TSR: begin
        if (xfer_done) begin
          if (pslverr) begin
            err_next   = 1'b1;
            state_next = STOP;
          end else if (abort_any || (period_cnt == target_reg)) begin
            state_next = STOP;
          end else begin
            state_next = GAP;
          end
        end
      end
      STOP: begin
        if (xfer_done) begin
          if (pslverr) begin
            err_next = 1'b1;
          end
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Address/direction/data for the transfer that starts when entering
  // state_next. The preload comes straight from the input on the start edge,
  // because the configuration is latched on that same edge.
  always_comb begin
    tdr_src     = (state_reg == IDLE) ? cfg_tdr : tdr_reg;
    setup_addr  = ADDR_TCR;
    setup_write = 1'b1;
    setup_data  = 8'h00;
    case (state_next)
      WR_TDR: begin
        setup_addr = ADDR_TDR;
        setup_data = tdr_src;
      end
      WR_LOAD: setup_data = 8'h80;
      WR_RUN:  setup_data = {2'b00, down_reg, 1'b1, 2'b00, cks_reg};
      RD_TSR: begin
        setup_addr  = ADDR_TSR;
        setup_write = 1'b0;
      end
      CLR_TSR: setup_addr = ADDR_TSR;
      default: ;
    endcase
  end

  // Every bus state has exactly one transfer. Entering one always opens a
  // fresh SETUP phase, and transfers can run back to back without an idle
  // cycle.
  assign launch = (state_next != state_reg) &&
                  (state_next != IDLE) && (state_next != GAP) &&
                  (state_next != DONE);

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_reg  <= IDLE;
      tdr_reg    <= 8'h00;
      down_reg   <= 1'b0;
      cks_reg    <= 2'b00;
      target_reg <= 8'd1;
      abort_reg  <= 1'b0;
      gap_reg    <= 8'd0;
      psel       <= 1'b0;
      penable    <= 1'b0;
      pwrite     <= 1'b0;
      paddr      <= 8'h00;
      pwdata     <= 8'h00;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      period_cnt <= 8'd0;
    end else begin
      state_reg  <= state_next;
      err        <= err_next;
      period_cnt <= cnt_next;
      busy       <= (state_next != IDLE);
      done       <= (state_next == DONE);

      if ((state_reg == IDLE) && start) begin
        tdr_reg    <= cfg_tdr;
        down_reg   <= cfg_down;
        cks_reg    <= cfg_cks;
        target_reg <= (cfg_periods == 8'd0) ? 8'd1 : cfg_periods;
        abort_reg  <= 1'b0;
      end else if (busy && abort) begin
        abort_reg <= 1'b1;
      end

      if ((state_next == GAP) && (state_reg != GAP)) begin
        gap_reg <= 8'd0;
      end else if (state_reg == GAP) begin
        gap_reg <= gap_reg + 8'd1;
      end

      if (launch) begin
        psel    <= 1'b1;
        penable <= 1'b0;
        paddr   <= setup_addr;
        pwrite  <= setup_write;
        pwdata  <= setup_data;
      end else if (psel && !penable) begin
        penable <= 1'b1;
      end else if (xfer_done) begin
        psel    <= 1'b0;
        penable <= 1'b0;
      end
    end
  end

endmodule
